// File: rtl/alu_issue_pkg.sv
// Shared types and width constants for the ALU issue queue.
// Optional statistics counters in alu_issue_q are enabled by defining ALU_ISSUE_STATS_EN.
package alu_issue_pkg;

    localparam int unsigned OPW = 3;
    localparam int unsigned DW  = 8;

    // One queued ALU operation: {opcode, ain, bin}, 19 bits.
    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic [DW-1:0]  ain;
        logic [DW-1:0]  bin;
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// Circular FIFO of op_t entries with occupancy count.
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
module alu_issue_fifo
    import alu_issue_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  op_t         wdata_i,
    output op_t         rdata_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    op_t           mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer / occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_issue_q.sv
// Operand queue and sequencer in front of a combinational 8-bit ALU.
// Operations are buffered, issued one at a time on registered ALU ports,
// and the captured result is held on a valid/ready port until taken.
// Define ALU_ISSUE_STATS_EN to add saturating op_cnt / zero_cnt outputs.
module alu_issue_q
    import alu_issue_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_opcode,
    input  logic [DW-1:0]  in_ain,
    input  logic [DW-1:0]  in_bin,
    output logic [DW-1:0]  ain,
    output logic [DW-1:0]  bin,
    output logic [OPW-1:0] opcode,
    input  logic [DW-1:0]  alu_out,
    input  logic           zero,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_data,
    output logic           res_zero,
    output logic [AW:0]    count
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]    op_cnt,
    output logic [15:0]    zero_cnt
`endif
);

    state_t         state_q, state_d;
    logic [DW-1:0]  ain_q, ain_d;
    logic [DW-1:0]  bin_q, bin_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [DW-1:0]  res_data_q, res_data_d;
    logic           res_zero_q, res_zero_d;
    logic           res_valid_q, res_valid_d;

    logic           issue;
    logic           fifo_full, fifo_empty;
    op_t            in_op, head_op;

    assign in_op = '{opcode: in_opcode, ain: in_ain, bin: in_bin};

    alu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .pop_i   (issue),
        .wdata_i (in_op),
        .rdata_o (head_op),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Full blocks intake for the whole cycle even if an issue pops that edge.
    assign in_ready  = !fifo_full;
    assign ain       = ain_q;
    assign bin       = bin_q;
    assign opcode    = opcode_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;

    // Sequencer: next state, issue strobe and next datapath register values.
    always_comb begin
        state_d     = state_q;
        ain_d       = ain_q;
        bin_d       = bin_q;
        opcode_d    = opcode_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_valid_d = res_valid_q;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    issue    = 1'b1;
                    ain_d    = head_op.ain;
                    bin_d    = head_op.bin;
                    opcode_d = head_op.opcode;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = alu_out;
                res_zero_d  = zero;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        issue    = 1'b1;
                        ain_d    = head_op.ain;
                        bin_d    = head_op.bin;
                        opcode_d = head_op.opcode;
                        state_d  = EXEC;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ain_q       <= '0;
            bin_q       <= '0;
            opcode_q    <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ain_q       <= ain_d;
            bin_q       <= bin_d;
            opcode_q    <= opcode_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [15:0] zero_cnt_q, zero_cnt_d;

    assign op_cnt   = op_cnt_q;
    assign zero_cnt = zero_cnt_q;

    // Saturating counts of executed operations and zero results.
    always_comb begin
        op_cnt_d   = op_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (state_q == EXEC) begin
            if (op_cnt_q != '1) begin
                op_cnt_d = op_cnt_q + 16'd1;
            end
            if (zero && (zero_cnt_q != '1)) begin
                zero_cnt_d = zero_cnt_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q   <= '0;
            zero_cnt_q <= '0;
        end else begin
            op_cnt_q   <= op_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_q.sv
// Directed self-checking bench for alu_issue_q with a behavioural ALU.
module tb_alu_issue_q;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [7:0] in_ain, in_bin;
    logic [7:0] ain, bin;
    logic [2:0] opcode;
    logic [7:0] alu_out;
    logic       zero;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic [4:0] count;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_cnt, zero_cnt;
`endif

    int         n_pass = 0;
    int         n_fail = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         last_hs = -1;
    int         n_results = 0;
    bit         chk_tput = 1'b0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = alu_f(op, a, b);
        return {(r == 8'h00), r};
    endfunction

    assign alu_out = alu_f(opcode, ain, bin);
    assign zero    = (alu_out == 8'h00);

    alu_issue_q #(
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_ain    (in_ain),
        .in_bin    (in_bin),
        .ain       (ain),
        .bin       (bin),
        .opcode    (opcode),
        .alu_out   (alu_out),
        .zero      (zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .count     (count)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .op_cnt    (op_cnt),
        .zero_cnt  (zero_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_opcode = op;
        in_ain    = a;
        in_bin    = b;
    endtask

    // Scoreboard bookkeeping on the pre-edge values, then advance one clock.
    task automatic cycle();
        logic [8:0] e;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_opcode, in_ain, in_bin));
        end
        if (res_valid && res_ready) begin
            check("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(e[7:0]));
                check("res_zero", 32'(res_zero), 32'(e[8]));
                n_results++;
                if (chk_tput && last_hs >= 0) begin
                    check("tput_gap", 32'(cyc - last_hs), 32'd2);
                end
                last_hs = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            cycle();
            guard++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int r0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        set_op(3'd0, 8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_ain", 32'(ain), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        rst_n = 1'b1;

        // Single op: add 12+34, latency push->issue->result
        res_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(3'd0, 8'h12, 8'h34);
        cycle();
        in_valid = 1'b0;
        check("t1_count_after_push", 32'(count), 32'd1);
        check("t1_no_result_yet", 32'(res_valid), 32'd0);
        cycle();
        check("t1_issue_ain", 32'(ain), 32'h12);
        check("t1_issue_bin", 32'(bin), 32'h34);
        check("t1_issue_opcode", 32'(opcode), 32'd0);
        check("t1_count_after_issue", 32'(count), 32'd0);
        check("t1_exec_res_valid", 32'(res_valid), 32'd0);
        cycle();
        check("t1_res_valid", 32'(res_valid), 32'd1);
        check("t1_res_data", 32'(res_data), 32'h46);
        check("t1_res_zero", 32'(res_zero), 32'd0);
        cycle();
        check("t1_idle_after_take", 32'(res_valid), 32'd0);

        // Hold: 55-55 = 0 held while res_ready low, next op waits
        res_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(3'd1, 8'h55, 8'h55);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        in_valid = 1'b1;
        set_op(3'd0, 8'h01, 8'h02);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(res_valid), 32'd1);
            check("t2_hold_data", 32'(res_data), 32'h00);
            check("t2_hold_zero", 32'(res_zero), 32'd1);
            check("t2_no_issue", 32'(ain), 32'h55);
            check("t2_queued", 32'(count), 32'd1);
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        check("t2_valid_drop", 32'(res_valid), 32'd0);
        check("t2_next_ain", 32'(ain), 32'h01);
        check("t2_next_bin", 32'(bin), 32'h02);
        cycle();
        check("t2_next_valid", 32'(res_valid), 32'd1);
        check("t2_next_data", 32'(res_data), 32'h03);
        cycle();
        check("t2_idle", 32'(res_valid), 32'd0);
        check("t2_empty", 32'(count), 32'd0);

        // Fill: 16 queued plus 1 held in HOLD, then drain in order
        res_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            set_op(3'(i % 2), 8'(i * 7 + 3), 8'(16 + i));
            check("t3_fill_ready", 32'(in_ready), 32'd1);
            cycle();
        end
        set_op(3'd4, 8'hA5, 8'h0F);
        check("t3_full_ready", 32'(in_ready), 32'd0);
        check("t3_full_count", 32'(count), 32'd16);
        res_ready = 1'b1;
        cycle();
        check("t3_pop_no_push_count", 32'(count), 32'd15);
        check("t3_ready_rises", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
        drain("t3_drain");
        check("t3_final_valid", 32'(res_valid), 32'd0);
        check("t3_final_count", 32'(count), 32'd0);

        // Streaming 20 ops with res_ready high: one result per 2 cycles
        chk_tput = 1'b1;
        last_hs  = -1;
        r0       = n_results;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            set_op(3'(i % 5), 8'(i * 13), 8'(i * 5 + 1));
            cycle();
        end
        in_valid = 1'b0;
        drain("t4_drain");
        chk_tput = 1'b0;
        check("t4_result_total", 32'(n_results - r0), 32'd20);

        // Reset while in HOLD with 4 queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            set_op(3'd0, 8'(i + 1), 8'h01);
            cycle();
        end
        in_valid = 1'b0;
        check("t5_pre_count", 32'(count), 32'd4);
        check("t5_pre_valid", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(res_valid), 32'd0);
        check("t5_rst_data", 32'(res_data), 32'd0);
        check("t5_rst_zero", 32'(res_zero), 32'd0);
        check("t5_rst_ain", 32'(ain), 32'd0);
        check("t5_rst_bin", 32'(bin), 32'd0);
        check("t5_rst_opcode", 32'(opcode), 32'd0);
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t5_no_stale_valid", 32'(res_valid), 32'd0);
            check("t5_no_stale_count", 32'(count), 32'd0);
        end

`ifdef ALU_ISSUE_STATS_EN
        check("st_rst_op_cnt", 32'(op_cnt), 32'd0);
        check("st_rst_zero_cnt", 32'(zero_cnt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            if (i == 2 || i == 5 || i == 8) begin
                set_op(3'd1, 8'(i * 3), 8'(i * 3));
            end else begin
                set_op(3'd0, 8'(i + 1), 8'h20);
            end
            cycle();
        end
        in_valid = 1'b0;
        drain("st_drain");
        cycle();
        check("st_op_cnt", 32'(op_cnt), 32'd10);
        check("st_zero_cnt", 32'(zero_cnt), 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
